// File: rtl/seq_shift_add_mult.sv
// rtl/seq_shift_add_mult.sv - iterative radix-2 shift-and-add multiplier, WIDTH cycles per product
// Optional two's-complement operands when SEQ_MULT_SIGNED_EN is defined.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     acc_nxt;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     mcand;
  logic [CW-1:0]        count;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [2*WIDTH-1:0]   result;
  logic                 accept;
  logic                 last_iter;

  assign accept    = in_valid && in_ready;
  assign last_iter = (count == CW'(0));

`ifdef SEQ_MULT_SIGNED_EN
  logic sign;

  // Magnitudes: the most-negative value negates to itself, which reads correctly as unsigned.
  assign op_a   = a[WIDTH-1] ? -a : a;
  assign op_b   = b[WIDTH-1] ? -b : b;
  assign result = sign ? -acc_nxt[2*WIDTH-1:0] : acc_nxt[2*WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign <= 1'b0;
    end else if (accept) begin
      sign <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign op_a   = a;
  assign op_b   = b;
  assign result = acc_nxt[2*WIDTH-1:0];
`endif

  // Top WIDTH+1 bits keep the adder carry, so the shifted-out accumulator never overflows.
  always_comb begin
    sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    acc_nxt = {1'b0, sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst_n && (state == IDLE);
    busy      = (state == CALC);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      if (accept) begin
        mcand <= op_a;
        acc   <= {{(WIDTH+1){1'b0}}, op_b};
        count <= CW'(WIDTH-1);
      end else if (state == CALC) begin
        acc   <= acc_nxt;
        count <= count - CW'(1);
        if (last_iter) begin
          product <= result;
        end
      end
    end
  end

endmodule
